// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master among N_REQ requesters.
// Each grant runs one complete transaction and returns the result to the winner.
module i2c_master_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 200_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            req_rw,
    input  logic [7*N_REQ-1:0]          req_addr,
    input  logic [DATA_WIDTH*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]       rsp_rdata,
    output logic                        rsp_err,
    output logic                        rsp_timeout,
    output logic                        m_start,
    output logic                        m_rw,
    output logic [6:0]                  m_addr,
    output logic [DATA_WIDTH-1:0]       m_wdata,
    input  logic                        m_busy,
    input  logic                        m_done,
    input  logic [DATA_WIDTH-1:0]       m_rdata,
    input  logic                        m_nack
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W:0]   N_REQ_W  = (PTR_W + 1)'(N_REQ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);

    typedef enum logic [1:0] {
        ARB,
        WAIT,
        RESP
    } state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] win_idx;
    logic [TMR_W-1:0] timer;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [PTR_W:0]   cand;

    logic [6:0]            addr_arr  [N_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[7*g +: 7];
        assign wdata_arr[g] = req_wdata[DATA_WIDTH*g +: DATA_WIDTH];
    end

    // Scan upward from rr_ptr; the extra bit lets the sum wrap for non-power-of-two N_REQ.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (PTR_W + 1)'(i);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            if (!pick_valid && req[cand[PTR_W-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB;
            rr_ptr      <= '0;
            win_idx     <= '0;
            timer       <= '0;
            gnt         <= '0;
            done        <= '0;
            m_start     <= 1'b0;
            m_rw        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            m_start <= 1'b0;
            done    <= '0;
            unique case (state)
                ARB: begin
                    if (pick_valid && !m_busy) begin
                        gnt     <= GNT_ONE << pick_idx;
                        win_idx <= pick_idx;
                        m_rw    <= req_rw[pick_idx];
                        m_addr  <= addr_arr[pick_idx];
                        m_wdata <= wdata_arr[pick_idx];
                        m_start <= 1'b1;
                        timer   <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + TMR_W'(1);
                    // A completion in the same cycle as the timeout takes precedence.
                    if (m_done) begin
                        rsp_rdata   <= m_rdata;
                        rsp_err     <= m_nack;
                        rsp_timeout <= 1'b0;
                        done        <= gnt;
                        state       <= RESP;
                    end else if (timer == TMR_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        done        <= gnt;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    gnt    <= '0;
                    rr_ptr <= (win_idx == PTR_LAST) ? '0 : win_idx + PTR_W'(1);
                    state  <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter: stimulus queues expected starts/responses,
// a negedge monitor pops and compares whenever m_start or done is seen.
module tb_i2c_master_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req, req_rw;
    logic [7*N-1:0]  req_addr;
    logic [DW*N-1:0] req_wdata;
    logic [N-1:0]    gnt, done;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, rsp_timeout;
    logic            m_start, m_rw;
    logic [6:0]      m_addr;
    logic [DW-1:0]   m_wdata;
    logic            m_busy, m_done, m_nack;
    logic [DW-1:0]   m_rdata;

    logic            mm_busy, mm_done, mm_nack, force_busy, inj_done;
    logic [DW-1:0]   mm_rdata;

    assign m_busy  = mm_busy | force_busy;
    assign m_done  = mm_done | inj_done;
    assign m_rdata = inj_done ? 8'hEE : mm_rdata;
    assign m_nack  = mm_nack | inj_done;

    i2c_master_arbiter #(
        .N_REQ(N),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req(req), .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_done(m_done), .m_rdata(m_rdata), .m_nack(m_nack)
    );

    typedef struct {
        int         idx;
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        int         exp_cyc;
    } start_t;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       err;
        logic       tmo;
        logic [7:0] wdata;
        int         lat;
    } rsp_t;

    typedef struct {
        int         lat;
        logic [7:0] rdata;
        logic       nack;
        logic       silent;
    } mst_t;

    start_t sq[$];
    rsp_t   rq[$];
    mst_t   mq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        req_rw[i]            = rw;
        req_addr[7*i +: 7]   = a;
        req_wdata[DW*i +: DW] = d;
    endtask

    task automatic push_start(input int idx, input logic rw, input logic [6:0] a,
                              input logic [7:0] d, input int ec);
        start_t s;
        s.idx = idx; s.rw = rw; s.addr = a; s.wdata = d; s.exp_cyc = ec;
        sq.push_back(s);
    endtask

    task automatic push_rsp(input int idx, input logic [7:0] rd, input logic err,
                            input logic tmo, input logic [7:0] wd, input int lat);
        rsp_t r;
        r.idx = idx; r.rdata = rd; r.err = err; r.tmo = tmo; r.wdata = wd; r.lat = lat;
        rq.push_back(r);
    endtask

    task automatic push_mst(input int lat, input logic [7:0] rd, input logic nack, input logic silent);
        mst_t m;
        m.lat = lat; m.rdata = rd; m.nack = nack; m.silent = silent;
        mq.push_back(m);
    endtask

    task automatic wait_dones(input int n, input bit hold);
        int cnt = 0;
        int b = 0;
        while (cnt < n && b < 3000) begin
            tick();
            b++;
            if (done != '0) begin
                cnt++;
                if (cnt == n) req = '0;
                else if (!hold) req = req & ~done;
            end
        end
        if (cnt < n) begin
            chk("done_wait_timeout", cnt, n);
            req = '0;
        end
    endtask

    task automatic wait_gnt();
        int b = 0;
        while (gnt == '0 && b < 500) begin
            tick();
            b++;
        end
        if (gnt == '0) chk("gnt_wait_timeout", gnt, 1);
    endtask

    // Master model: answers each m_start with the next queued response.
    initial begin
        mst_t m;
        mm_busy = 1'b0; mm_done = 1'b0; mm_nack = 1'b0; mm_rdata = '0;
        forever begin
            tick();
            if (m_start && rst_n) begin
                if (mq.size() == 0) m.silent = 1'b1;
                else m = mq.pop_front();
                if (!m.silent) begin
                    mm_busy = 1'b1;
                    repeat (m.lat - 1) tick();
                    mm_rdata = m.rdata;
                    mm_nack  = m.nack;
                    mm_done  = 1'b1;
                    tick();
                    mm_done = 1'b0;
                    mm_nack = 1'b0;
                    mm_busy = 1'b0;
                end
            end
        end
    end

    start_t ms;
    rsp_t   mr;
    logic [N-1:0] oh;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_start) begin
                if (sq.size() == 0) begin
                    chk("start_without_request", m_start, 0);
                end else begin
                    ms = sq.pop_front();
                    oh = 4'b0001 << ms.idx;
                    chk("start_gnt", gnt, oh);
                    chk("start_rw", m_rw, ms.rw);
                    chk("start_addr", m_addr, ms.addr);
                    chk("start_wdata", m_wdata, ms.wdata);
                    if (ms.exp_cyc >= 0) chk("start_cycle", cyc, ms.exp_cyc);
                end
                last_start = cyc;
            end
            if (done != '0) begin
                if (rq.size() == 0) begin
                    chk("done_without_txn", done, 0);
                end else begin
                    mr = rq.pop_front();
                    oh = 4'b0001 << mr.idx;
                    chk("done_vec", done, oh);
                    chk("done_gnt", gnt, oh);
                    chk("rsp_rdata", rsp_rdata, mr.rdata);
                    chk("rsp_err", rsp_err, mr.err);
                    chk("rsp_timeout", rsp_timeout, mr.tmo);
                    chk("held_wdata", m_wdata, mr.wdata);
                    if (mr.lat > 0) chk("done_latency", cyc - last_start, mr.lat);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        force_busy = 1'b0; inj_done = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_m_start", m_start, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Round robin with all requests held: 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 7'h10 + 7'(i), 8'h20 + 8'(i));
        for (int k = 0; k < 5; k++) begin
            push_start(k % N, 1'b0, 7'h10 + 7'(k % N), 8'h20 + 8'(k % N), (k == 0) ? cyc + 1 : -1);
            push_mst(10, 8'h40 + 8'(k), 1'b0, 1'b0);
            push_rsp(k % N, 8'h40 + 8'(k), 1'b0, 1'b0, 8'h20 + 8'(k % N), 0);
        end
        req = '1;
        wait_dones(5, 1'b1);
        repeat (2) tick();

        // Single write from requester 0, master takes 50 cycles.
        set_req(0, 1'b0, 7'h55, 8'hA5);
        push_start(0, 1'b0, 7'h55, 8'hA5, cyc + 1);
        push_mst(50, 8'h00, 1'b0, 1'b0);
        push_rsp(0, 8'h00, 1'b0, 1'b0, 8'hA5, 0);
        req = 4'b0001;
        wait_dones(1, 1'b0);
        repeat (2) tick();

        // rr_ptr=1: requester 2 (read 0x3C) wins over 0, then 0 gets a NACK.
        set_req(0, 1'b0, 7'h33, 8'h77);
        set_req(2, 1'b1, 7'h2A, 8'h00);
        push_start(2, 1'b1, 7'h2A, 8'h00, cyc + 1);
        push_start(0, 1'b0, 7'h33, 8'h77, -1);
        push_mst(20, 8'h3C, 1'b0, 1'b0);
        push_mst(15, 8'h99, 1'b1, 1'b0);
        push_rsp(2, 8'h3C, 1'b0, 1'b0, 8'h00, 0);
        push_rsp(0, 8'h99, 1'b1, 1'b0, 8'h77, 0);
        req = 4'b0101;
        wait_dones(2, 1'b0);
        repeat (2) tick();

        // Master never answers: timeout after exactly TMO cycles.
        set_req(3, 1'b1, 7'h68, 8'h5E);
        push_start(3, 1'b1, 7'h68, 8'h5E, cyc + 1);
        push_mst(0, 8'h00, 1'b0, 1'b1);
        push_rsp(3, 8'h00, 1'b1, 1'b1, 8'h5E, TMO);
        req = 4'b1000;
        wait_dones(1, 1'b0);
        repeat (2) tick();

        // Stray m_done while idle must not disturb the held response.
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        repeat (3) tick();
        chk("stray_rsp_rdata", rsp_rdata, 8'h00);
        chk("stray_rsp_err", rsp_err, 1);
        chk("stray_rsp_timeout", rsp_timeout, 1);

        // Busy master blocks grants; inputs changed after grant are ignored.
        set_req(1, 1'b0, 7'h12, 8'hC3);
        force_busy = 1'b1;
        req = 4'b0010;
        repeat (6) tick();
        chk("busy_no_gnt", gnt, 0);
        push_start(1, 1'b0, 7'h12, 8'hC3, cyc + 1);
        push_mst(30, 8'h5A, 1'b0, 1'b0);
        push_rsp(1, 8'h5A, 1'b0, 1'b0, 8'hC3, 0);
        force_busy = 1'b0;
        wait_gnt();
        tick();
        set_req(1, 1'b1, 7'h7F, 8'hFF);
        wait_dones(1, 1'b0);
        repeat (2) tick();

        // Reset mid-WAIT while requester 2 is granted (rr_ptr=2 beforehand).
        set_req(2, 1'b0, 7'h44, 8'h9D);
        push_start(2, 1'b0, 7'h44, 8'h9D, cyc + 1);
        push_mst(0, 8'h00, 1'b0, 1'b1);
        req = 4'b0100;
        wait_gnt();
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("async_rst_gnt", gnt, 0);
        chk("async_rst_m_start", m_start, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_m_addr", m_addr, 0);
        chk("async_rst_m_wdata", m_wdata, 0);
        chk("async_rst_rsp_err", rsp_err, 0);
        chk("async_rst_rsp_timeout", rsp_timeout, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();

        // After reset rr_ptr=0, so 0 wins over 2.
        set_req(0, 1'b1, 7'h01, 8'h00);
        push_start(0, 1'b1, 7'h01, 8'h00, cyc + 1);
        push_start(2, 1'b0, 7'h44, 8'h9D, -1);
        push_mst(10, 8'hB7, 1'b0, 1'b0);
        push_mst(10, 8'h00, 1'b0, 1'b0);
        push_rsp(0, 8'hB7, 1'b0, 1'b0, 8'h00, 0);
        push_rsp(2, 8'h00, 1'b0, 1'b0, 8'h9D, 0);
        req = 4'b0101;
        wait_dones(2, 1'b0);
        repeat (3) tick();

        chk("start_queue_drained", sq.size(), 0);
        chk("rsp_queue_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_arbiter.md
Name: i2c_master_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one byte-level I2C master among N_REQ requesters (sensor poller, config loader, debug bridge, ...).
- Each request is one complete single-byte transaction: START, address+R/W, data byte, STOP.
- The arbiter latches the winner's command, issues it to the master, waits for completion or timeout, and returns the result to the winner.
- Sits between the requester blocks and the I2C master FSM in the Basys3 top level.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, data byte width
TIMEOUT_CYCLES, 200_000, clk cycles allowed from m_start to m_done (2 ms at 100 MHz)

Ports:
clk  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level
req_rw  in  N_REQ  per-requester R/W (0=write, 1=read)
req_addr  in  7*N_REQ  per-requester 7-bit slave address, packed, requester i at [7i+6:7i]
req_wdata  in  DATA_WIDTH*N_REQ  per-requester write byte, packed
gnt  out  N_REQ  one-hot grant, held for the whole transaction
done  out  N_REQ  one-cycle completion pulse to the granted requester
rsp_rdata  out  DATA_WIDTH  read byte, valid while done pulses
rsp_err  out  1  NACK or timeout, valid while done pulses
rsp_timeout  out  1  timeout cause, valid while done pulses
m_start  out  1  one-cycle start pulse to the master
m_rw  out  1  latched R/W
m_addr  out  7  latched address
m_wdata  out  DATA_WIDTH  latched write byte
m_busy  in  1  master not idle
m_done  in  1  master completion pulse
m_rdata  in  DATA_WIDTH  master read byte
m_nack  in  1  master saw NACK, valid with m_done

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, done=0, m_start=0, m_rw=0, m_addr=0, m_wdata=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, rr_ptr=0, state=ARB, timer=0.
- FSM states: ARB, WAIT, RESP.
- ARB:
  - If any req is set and m_busy=0, pick the first set req bit scanning upward from rr_ptr, wrapping modulo N_REQ.
  - On that edge: set gnt one-hot for the winner, latch its rw/addr/wdata onto m_*, pulse m_start for exactly one cycle, clear timer, go to WAIT.
  - Latency: gnt and m_start are high in the cycle after the edge at which req was sampled high.
  - If m_busy=1, hold in ARB and do not grant.
- WAIT:
  - gnt and m_* are held stable; timer increments every cycle.
  - m_done=1: capture rsp_rdata=m_rdata, rsp_err=m_nack, rsp_timeout=0; go to RESP.
  - Otherwise, timer reaching TIMEOUT_CYCLES-1: rsp_rdata=0, rsp_err=1, rsp_timeout=1; go to RESP.
  - If m_done and the timeout occur in the same cycle, m_done wins.
- RESP (one cycle):
  - done[winner]=1 and gnt still high; rsp_* valid.
  - Next edge: gnt=0, done=0, rr_ptr=(winner+1) mod N_REQ, state=ARB.
- Throughput: minimum 3 cycles per transaction in the arbiter (ARB, WAIT, RESP) plus master time. No back-to-back grants without a pass through ARB.
- A requester dropping req while granted is ignored; the transaction completes and done still pulses.
- A requester must keep req high until it gets gnt. It must drop req the cycle after done, or it becomes eligible again, at lowest priority.
- Only the granted requester's inputs are sampled, and only at the ARB grant edge. Changes after that edge do not affect m_*.
- m_done arriving outside WAIT is ignored.
- rsp_* hold their last values until the next RESP or a reset.
- Reset mid-transaction: all outputs return to reset values immediately. The master must be reset by the same rst_n; no STOP is generated by this block.
- timer width: $clog2(TIMEOUT_CYCLES)+1 bits. rr_ptr width: $clog2(N_REQ) bits; wrap to 0 explicitly when N_REQ is not a power of two.

Test Plan:
- req=4'b0001, rw=0, addr=0x55, wdata=0xA5; master model returns m_done after 50 cycles, m_nack=0 -> gnt=0001 and m_start pulse one cycle after req; m_addr=0x55, m_wdata=0xA5; done[0] pulse with rsp_err=0; rr_ptr=1.
- req=4'b1111 held, each master transaction completes after 10 cycles -> grant order 0,1,2,3,0; each gnt one-hot; exactly one done per grant.
- Read from requester 2, master returns m_rdata=0x3C -> done[2] with rsp_rdata=0x3C, rsp_err=0. Then m_nack=1 on the next transaction -> rsp_err=1, rsp_timeout=0.
- Master never asserts m_done, TIMEOUT_CYCLES=100 -> done pulses exactly 100 cycles after the WAIT entry edge, with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- m_busy=1 while req=0010 -> no gnt and no m_start. m_busy falls -> gnt=0010 next cycle. Requester changes req_wdata during WAIT -> m_wdata unchanged.
- rst_n pulled low during WAIT with gnt=0100 -> gnt, m_start and done read 0 with no clock edge; after release, req=0001 grants requester 0 (rr_ptr=0).
